// File: rtl/truth_table_sweeper.sv
// Drives all 16 input vectors to a 4-input combinational block, captures its
// response into a truth table and grades it against a golden pattern.
module truth_table_sweeper #(
  parameter int unsigned DWELL    = 4,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic        fail_valid,
  output logic [3:0]  first_fail_idx,
  output logic        pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        wrap_q, wrap_d;
  logic [3:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  mis_q, mis_d;
  logic        fv_q, fv_d;
  logic [3:0]  ffi_q, ffi_d;

  // State register and all result/stimulus flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      dwell_q <= 8'd0;
      wrap_q  <= 1'b0;
      vec_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= 16'h0000;
      mis_q   <= 5'd0;
      fv_q    <= 1'b0;
      ffi_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      mis_q   <= mis_d;
      fv_q    <= fv_d;
      ffi_q   <= ffi_d;
    end
  end

  // Next-state, sweep sequencing and capture/compare
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    wrap_d  = wrap_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    table_d = table_q;
    mis_d   = mis_q;
    fv_d    = fv_q;
    ffi_d   = ffi_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = 4'd0;
          dwell_d = 8'd0;
          wrap_d  = 1'b0;
          vec_d   = 4'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          table_d = 16'h0000;
          mis_d   = 5'd0;
          fv_d    = 1'b0;
          ffi_d   = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        // wrap_q marks the single settling cycle after the index-15 capture
        if (wrap_q) begin
          state_d = S_DONE;
          wrap_d  = 1'b0;
          idx_d   = 4'd0;
          dwell_d = 8'd0;
          vec_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (dwell_q == DWELL_LAST) begin
          table_d[idx_q] = f;
          dwell_d        = 8'd0;
          if (f != EXPECTED[idx_q]) begin
            mis_d = mis_q + 5'd1;
            if (!fv_q) begin
              fv_d  = 1'b1;
              ffi_d = idx_q;
            end else begin
              fv_d = fv_q;
            end
          end else begin
            mis_d = mis_q;
          end
          if (idx_q == 4'd15) begin
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
            vec_d = idx_q + 4'd1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign {a, b, c, d}   = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = table_q;
  assign mismatch_cnt   = mis_q;
  assign fail_valid     = fv_q;
  assign first_fail_idx = ffi_q;
  assign pass           = done_q && (mis_q == 5'd0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table-driven sweeps with a result scoreboard,
// plus reset-mid-sweep, held-start and single-cycle-dwell sequences.
module tb_truth_table_sweeper;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] tbl;
    logic [4:0]  cnt;
    logic        fv;
    logic [3:0]  ffi;
    logic        pss;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0;
  logic start1 = 1'b0;
  logic [1:0] mode = 2'd0;
  bit use1 = 1'b0;

  logic a4, b4, c4, d4, f4, busy4, done4, fv4, pass4;
  logic [15:0] tbl4;
  logic [4:0]  cnt4;
  logic [3:0]  ffi4;
  logic a1, b1, c1, d1, f1, busy1, done1, fv1, pass1;
  logic [15:0] tbl1;
  logic [4:0]  cnt1;
  logic [3:0]  ffi1;

  logic [3:0]  cur_abcd;
  logic        cur_busy, cur_done, cur_fv, cur_pass;
  logic [15:0] cur_tbl;
  logic [4:0]  cur_cnt;
  logic [3:0]  cur_ffi;

  int checks = 0;
  int errors = 0;
  vec_t vecs[3];
  vec_t sb[$];

  always #5 clk = ~clk;

  // Downstream function models
  assign f4 = (mode == 2'd0) ? ^{a4, b4, c4, d4} :
              (mode == 2'd1) ? 1'b0 :
              (^{a4, b4, c4, d4}) ^ ({a4, b4, c4, d4} == 4'd15);
  assign f1 = ^{a1, b1, c1, d1};

  assign cur_abcd = use1 ? {a1, b1, c1, d1} : {a4, b4, c4, d4};
  assign cur_busy = use1 ? busy1 : busy4;
  assign cur_done = use1 ? done1 : done4;
  assign cur_fv   = use1 ? fv1 : fv4;
  assign cur_pass = use1 ? pass1 : pass4;
  assign cur_tbl  = use1 ? tbl1 : tbl4;
  assign cur_cnt  = use1 ? cnt1 : cnt4;
  assign cur_ffi  = use1 ? ffi1 : ffi4;

  truth_table_sweeper #(.DWELL(4), .EXPECTED(16'h6996)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a(a4), .b(b4), .c(c4), .d(d4), .f(f4),
    .busy(busy4), .done(done4), .table_out(tbl4), .mismatch_cnt(cnt4),
    .fail_valid(fv4), .first_fail_idx(ffi4), .pass(pass4)
  );

  truth_table_sweeper #(.DWELL(1), .EXPECTED(16'h6996)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .f(f1),
    .busy(busy1), .done(done1), .table_out(tbl1), .mismatch_cnt(cnt1),
    .fail_valid(fv1), .first_fail_idx(ffi1), .pass(pass1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_abcd"}, int'(cur_abcd), 0);
    chk({tag, "_busy"}, int'(cur_busy), 0);
    chk({tag, "_done"}, int'(cur_done), 0);
    chk({tag, "_table"}, int'(cur_tbl), 0);
    chk({tag, "_cnt"}, int'(cur_cnt), 0);
    chk({tag, "_fv"}, int'(cur_fv), 0);
    chk({tag, "_ffi"}, int'(cur_ffi), 0);
    chk({tag, "_pass"}, int'(cur_pass), 0);
  endtask

  task automatic pulse_start();
    if (use1) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Entered just after the edge that accepted start; checks each vector's
  // hold window, done latency, then scores the popped expected result.
  task automatic wait_done(input int dw);
    int n;
    vec_t e;
    n = 0;
    while (!cur_done && n < 16 * dw + 10) begin
      if (n < 16 * dw) begin
        chk("vector", int'(cur_abcd), n / dw);
        chk("busy_run", int'(cur_busy), 1);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("done_latency", n, 16 * dw + 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("table_out", int'(cur_tbl), int'(e.tbl));
      chk("mismatch_cnt", int'(cur_cnt), int'(e.cnt));
      chk("fail_valid", int'(cur_fv), int'(e.fv));
      chk("first_fail_idx", int'(cur_ffi), int'(e.ffi));
      chk("pass", int'(cur_pass), int'(e.pss));
      chk("busy_done", int'(cur_busy), 0);
      chk("abcd_done", int'(cur_abcd), 0);
    end
  endtask

  initial begin
    int w;
    vecs[0] = '{mode: 2'd0, tbl: 16'h6996, cnt: 5'd0, fv: 1'b0, ffi: 4'd0,  pss: 1'b1};
    vecs[1] = '{mode: 2'd1, tbl: 16'h0000, cnt: 5'd8, fv: 1'b1, ffi: 4'd1,  pss: 1'b0};
    vecs[2] = '{mode: 2'd2, tbl: 16'hE996, cnt: 5'd1, fv: 1'b1, ffi: 4'd15, pss: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset4");
    use1 = 1'b1;
    chk_cleared("reset1");
    use1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      mode = vecs[i].mode;
      sb.push_back(vecs[i]);
      pulse_start();
      wait_done(4);
    end

    // Reset while vector 0111 is driven
    mode = 2'd0;
    pulse_start();
    w = 0;
    while (cur_abcd != 4'd7 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reach_0111", int'(cur_abcd), 7);
    #2 rst_n = 1'b0;
    #1 chk_cleared("midreset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cleared("after_reset");
    sb.push_back(vecs[0]);
    pulse_start();
    wait_done(4);

    // start held high: ignored in RUN, done lasts one cycle, then re-sweep
    start4 = 1'b1;
    @(posedge clk); #1;
    sb.push_back(vecs[0]);
    wait_done(4);
    @(posedge clk); #1;
    chk("held_done_drop", int'(cur_done), 0);
    chk("held_busy", int'(cur_busy), 1);
    chk("held_table_clr", int'(cur_tbl), 0);
    chk("held_cnt_clr", int'(cur_cnt), 0);
    sb.push_back(vecs[0]);
    wait_done(4);
    start4 = 1'b0;
    @(posedge clk); #1;
    chk("held_done_stays", int'(cur_done), 1);
    chk("held_idle_busy", int'(cur_busy), 0);

    // Single-cycle dwell
    use1 = 1'b1;
    sb.push_back(vecs[0]);
    pulse_start();
    wait_done(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage placed directly upstream of a 4-input combinational function block, e.g. odev1_b with inputs a,b,c,d and output f.
- On start, drives all 16 input combinations in ascending order and holds each one for a programmable dwell time.
- Samples f once per vector and assembles a 16-bit truth table.
- Compares the table against a golden value and reports pass/fail, mismatch count and first failing index.

Parameters:
- DWELL, 4, clock cycles each vector is held; legal range 1..255.
- EXPECTED, 16'h0000, golden truth table; bit i is the expected f for input index i.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request, sampled on rising edge of clk.
- a  output  1  stimulus bit 3 (MSB of index).
- b  output  1  stimulus bit 2.
- c  output  1  stimulus bit 1.
- d  output  1  stimulus bit 0 (LSB).
- f  input  1  response of the downstream function block.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- table_out  output  16  captured truth table; bit idx = f sampled for {a,b,c,d}=idx.
- mismatch_cnt  output  5  number of bits where table_out differs from EXPECTED (0..16).
- fail_valid  output  1  high when at least one mismatch has been recorded.
- first_fail_idx  output  4  lowest mismatching index; valid only when fail_valid=1.
- pass  output  1  done && mismatch_cnt==0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; a,b,c,d=0; busy=0; done=0; table_out=0; mismatch_cnt=0; fail_valid=0; first_fail_idx=0; pass=0; internal idx=0; dwell_cnt=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN.
  - On entry to RUN: idx=0, dwell_cnt=0, busy=1; clear table_out, mismatch_cnt, fail_valid, first_fail_idx.
  - {a,b,c,d}=0000 from the next cycle onward.
- RUN:
  - {a,b,c,d} always equals idx.
  - dwell_cnt increments each cycle.
  - When dwell_cnt==DWELL-1 (last dwell cycle), capture f into table_out[idx].
  - Compare f with EXPECTED[idx] in the same cycle. On mismatch: increment mismatch_cnt. If fail_valid was 0, set first_fail_idx=idx and fail_valid=1.
  - After capture, dwell_cnt=0 and idx=idx+1.
  - Capture at idx=15 -> DONE. busy=0 and done=1 on the following cycle; a,b,c,d return to 0.
  - start is ignored while in RUN.
- DONE:
  - Results held stable; pass is combinational from done and mismatch_cnt.
  - start=1 -> same action as from IDLE: results cleared, done=0, busy=1.
- Latency: start sampled at edge T -> first vector driven after T. Vector k is held for cycles T+1+k*DWELL .. T+(k+1)*DWELL. done=1 after edge T+16*DWELL+1.
- DWELL=1: one vector per cycle; f is sampled in the same cycle the vector is driven. The downstream block must settle within one cycle.
- idx is 4 bits with no wrap-around. Completion is detected at idx=15 before any increment.
- mismatch_cnt is 5 bits so a value of 16 is representable.
- Reset asserted mid-sweep: immediate return to the reset state. No partial results are retained. The next start begins at 0000.
- Outputs a,b,c,d, busy, done and results are all registered; no combinational path from f to any output except through the capture registers.

Test Plan:
- DWELL=4, EXPECTED=16'h6996, f=a^b^c^d model, single-cycle start at edge T -> each vector 0000..1111 held exactly 4 cycles. done=1 after edge T+65; table_out=16'h6996, mismatch_cnt=0, fail_valid=0, pass=1.
- Same setup with f tied to 0 -> table_out=16'h0000, mismatch_cnt=8, fail_valid=1, first_fail_idx=1, pass=0.
- f model inverted only at index 15 -> mismatch_cnt=1, first_fail_idx=15, pass=0.
- rst_n pulsed low while {a,b,c,d}=0111 -> all outputs 0 immediately. Subsequent start restarts the sweep at 0000 and completes with table_out=16'h6996.
- start held high continuously -> ignored during RUN. done high for exactly one cycle, then a new sweep starts with results cleared and busy=1.
- DWELL=1 with the parity model -> vectors change every cycle, done=1 after edge T+17, table_out=16'h6996.
